// File: rtl/dshot_encoder_pkg.sv
// Motor output constants, DShot state encoding and the mixer-to-DShot throttle map.
// Shared by the encoder and the future telemetry decoder.
package dshot_encoder_pkg;

  localparam int DSHOT_CMD_MIN       = 48;
  localparam int DSHOT_CMD_MAX       = 2047;
  localparam int DSHOT_THROTTLE_SPAN = 1999;
  localparam int DSHOT_CMD_BITS      = 11;
  localparam int DSHOT_FRAME_BITS    = 16;
  localparam int MIX_FRAC_BITS       = 28;

  localparam logic signed [31:0] MIX_ONE = 32'sh1000_0000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    GAP
  } dshot_state_e;

  // Q4.28 mixer output to DShot throttle; command 0 when disarmed.
  function automatic logic [DSHOT_CMD_BITS-1:0] dshot_map_throttle(
    input logic              arm_i,
    input logic signed [31:0] x_i
  );
    logic signed [63:0]        prod;
    logic [DSHOT_CMD_BITS-1:0] cmd;
    prod = 64'(x_i) * 64'(DSHOT_THROTTLE_SPAN);
    if (!arm_i) begin
      cmd = '0;
    end else if (x_i <= 32'sd0) begin
      cmd = DSHOT_CMD_BITS'(DSHOT_CMD_MIN);
    end else if (x_i >= MIX_ONE) begin
      cmd = DSHOT_CMD_BITS'(DSHOT_CMD_MAX);
    end else begin
      cmd = DSHOT_CMD_BITS'(DSHOT_CMD_MIN) + DSHOT_CMD_BITS'(prod >>> MIX_FRAC_BITS);
    end
    return cmd;
  endfunction

endpackage

// File: rtl/dshot_crc4.sv
// DShot 4-bit checksum: XOR of the three nibbles of the 12-bit throttle+telemetry word.
module dshot_crc4 (
  input  logic [11:0] data_i,
  output logic [3:0]  crc_o
);

  assign crc_o = data_i[3:0] ^ data_i[7:4] ^ data_i[11:8];

endmodule

// File: rtl/dshot_encoder.sv
// Per-motor DShot output stage: maps the mixer throttle to a DShot frame and
// serialises it MSB-first with programmable bit timing and an inter-frame gap.
module dshot_encoder
  import dshot_encoder_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 80,
  parameter int unsigned T1H_CYCLES = 60,
  parameter int unsigned T0H_CYCLES = 30,
  parameter int unsigned GAP_CYCLES = 2000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        trigger,
  input  logic                        armed,
  input  logic                        telemetry_req,
  input  logic signed [31:0]          mixedThrottle,
  output logic                        dshot_out,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        dropped,
  output logic [DSHOT_FRAME_BITS-1:0] frame_word
);

  localparam int IDX_W = $clog2(DSHOT_FRAME_BITS);

  localparam logic [15:0]      BIT_LAST = 16'(BIT_CYCLES - 1);
  localparam logic [15:0]      GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [15:0]      T1H_LIM  = 16'(T1H_CYCLES);
  localparam logic [15:0]      T0H_LIM  = 16'(T0H_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(DSHOT_FRAME_BITS - 1);

  dshot_state_e                state_q, state_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic [IDX_W-1:0]            bit_idx_q, bit_idx_d;
  logic [DSHOT_FRAME_BITS-1:0] frame_q, frame_d;
  logic signed [31:0]          thr_q, thr_d;
  logic                        armed_q, armed_d;
  logic                        telem_q, telem_d;
  logic                        dshot_out_q, dshot_out_d;
  logic                        busy_q, busy_d;
  logic                        frame_done_q, frame_done_d;
  logic                        dropped_q, dropped_d;

  logic [DSHOT_CMD_BITS-1:0]   load_cmd;
  logic [11:0]                 load_v12;
  logic [3:0]                  load_crc;
  logic [15:0]                 high_lim;
  logic                        bit_last;
  logic                        gap_last;

  assign load_cmd = dshot_map_throttle(armed_q, thr_q);
  assign load_v12 = {load_cmd, telem_q};

  dshot_crc4 u_crc (
    .data_i (load_v12),
    .crc_o  (load_crc)
  );

  assign high_lim = frame_q[bit_idx_q] ? T1H_LIM : T0H_LIM;
  assign bit_last = (cnt_q == BIT_LAST);
  assign gap_last = (cnt_q == GAP_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      frame_q      <= '0;
      thr_q        <= '0;
      armed_q      <= 1'b0;
      telem_q      <= 1'b0;
      dshot_out_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      frame_q      <= frame_d;
      thr_q        <= thr_d;
      armed_q      <= armed_d;
      telem_q      <= telem_d;
      dshot_out_q  <= dshot_out_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      dropped_q    <= dropped_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger) state_d = LOAD;
      LOAD:    state_d = SEND;
      SEND:    if (bit_last && (bit_idx_q == '0)) state_d = GAP;
      GAP:     if (gap_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    frame_d      = frame_q;
    thr_d        = thr_q;
    armed_d      = armed_q;
    telem_d      = telem_q;
    dshot_out_d  = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = (state_d != IDLE);
    // Any trigger outside IDLE is lost, including one on the last GAP cycle.
    dropped_d    = trigger && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (trigger) begin
          thr_d   = mixedThrottle;
          armed_d = armed;
          telem_d = telemetry_req;
        end
      end
      LOAD: begin
        frame_d   = {load_v12, load_crc};
        bit_idx_d = IDX_MSB;
        cnt_d     = '0;
      end
      SEND: begin
        dshot_out_d = (cnt_q < high_lim);
        if (bit_last) begin
          cnt_d = '0;
          if (bit_idx_q != '0) bit_idx_d = bit_idx_q - 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (gap_last) begin
          cnt_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign dshot_out  = dshot_out_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign dropped    = dropped_q;
  assign frame_word = frame_q;

endmodule
